// File: rtl/switch_debounce_pkg.sv
// Shared constants for the switch debouncer and the downstream pulse stage.
// The pulse stage uses the same slowref period as the debouncer.
package switch_debounce_pkg;

  localparam int NSW_DEF        = 4;
  localparam int DIV_DEF        = 50000;
  localparam int NSTABLE_DEF    = 4;
  localparam int SLOWREF_PERIOD = DIV_DEF;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bundle: raw levels in, sample strobe and debounced levels out.
interface switch_debounce_if #(
  parameter int NSW = 4
);
  logic [NSW-1:0] rawsw;
  logic           slowref;
  logic [NSW-1:0] cleansw;

  modport master (output rawsw, input  slowref, input  cleansw);
  modport slave  (input  rawsw, output slowref, output cleansw);
endinterface

// File: rtl/switch_debounce_cell.sv
// One switch: 2-flop synchronizer, stability counter and the clean level flop.
module debounce_cell #(
  parameter int NSTABLE = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic raw,
  input  logic strobe,
  output logic clean
);
  localparam int           CW  = $clog2(NSTABLE + 1);
  localparam logic [CW-1:0] TOP = CW'(NSTABLE - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          clean_q, clean_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (strobe) begin
      // Any agreeing sample discards the partial count, which rejects bounce.
      if (sync2_q == clean_q) begin
        cnt_d = '0;
      end else if (cnt_q >= TOP) begin
        clean_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;
endmodule

// File: rtl/switch_debounce.sv
// Multi-switch debouncer: shared prescaler strobe drives NSW independent cells.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int NSW     = NSW_DEF,
  parameter int DIV     = DIV_DEF,
  parameter int NSTABLE = NSTABLE_DEF
) (
  input  logic           clk,
  input  logic           resetb,
  input  logic [NSW-1:0] rawsw,
  output logic           slowref,
  output logic [NSW-1:0] cleansw
);
  localparam int           PW   = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          slowref_q, slowref_d;
  logic          strobe;

  // Cells update on the wrap edge, the same edge that raises slowref_q,
  // so cleansw changes only while slowref is high.
  always_comb begin
    strobe    = (pre_q == LAST);
    pre_d     = strobe ? '0 : pre_q + PW'(1);
    slowref_d = strobe;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pre_q     <= '0;
      slowref_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      slowref_q <= slowref_d;
    end
  end

  assign slowref = slowref_q;

  for (genvar g = 0; g < NSW; g++) begin : g_cell
    debounce_cell #(.NSTABLE(NSTABLE)) u_cell (
      .clk    (clk),
      .resetb (resetb),
      .raw    (rawsw[g]),
      .strobe (strobe),
      .clean  (cleansw[g])
    );
  end
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DIV=4, NSTABLE=3, NSW=2.
module tb_switch_debounce;
  localparam int NSW = 2, DIV = 4, NSTABLE = 3;

  logic clk = 1'b0;
  logic resetb;
  int   n_cmp = 0, n_bad = 0, ecnt = 0;

  switch_debounce_if #(.NSW(NSW)) sw_if ();

  switch_debounce #(.NSW(NSW), .DIV(DIV), .NSTABLE(NSTABLE)) dut (
    .clk     (clk),
    .resetb  (resetb),
    .rawsw   (sw_if.rawsw),
    .slowref (sw_if.slowref),
    .cleansw (sw_if.cleansw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] raw;
    logic       sr;
    logic [1:0] cs;
  } vec_t;
  vec_t tbl[24];

  task automatic chk(input string nm, input logic [1:0] exp_cs, input logic exp_sr);
    n_cmp++;
    if (sw_if.cleansw !== exp_cs) begin
      n_bad++;
      $display("FAIL %s edge %0d cleansw got %b want %b", nm, ecnt, sw_if.cleansw, exp_cs);
    end
    n_cmp++;
    if (sw_if.slowref !== exp_sr) begin
      n_bad++;
      $display("FAIL %s edge %0d slowref got %b want %b", nm, ecnt, sw_if.slowref, exp_sr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int e, input string nm, input logic [1:0] exp_cs, input logic exp_sr);
    while (ecnt < e) step();
    chk(nm, exp_cs, exp_sr);
  endtask

  // Reset pulse launched just after a sample point; released on the next negedge.
  task automatic pulse_reset(input string nm);
    resetb = 1'b0;
    #2;
    chk(nm, 2'b00, 1'b0);
    @(negedge clk);
    resetb = 1'b1;
    ecnt   = 0;
  endtask

  initial begin
    resetb      = 1'b0;
    sw_if.rawsw = '0;
    #12;
    chk("reset_state", 2'b00, 1'b0);
    @(negedge clk);
    resetb = 1'b1;
    ecnt   = 0;

    // Idle for 8 edges, then bit0 rises before edge 9: sync high after edge 10,
    // strobes at 12,16,20 qualify, so cleansw[0] sets at edge 20.
    for (int k = 1; k <= 24; k++) begin
      tbl[k-1].raw = (k >= 9) ? 2'b01 : 2'b00;
      tbl[k-1].sr  = (k % 4 == 0);
      tbl[k-1].cs  = (k >= 20) ? 2'b01 : 2'b00;
    end
    for (int i = 0; i < 24; i++) begin
      sw_if.rawsw = tbl[i].raw;
      step();
      chk("table", tbl[i].cs, tbl[i].sr);
    end

    // Bounce on bit1: one disagreeing strobe (28) then agreeing (32).
    sw_if.rawsw = 2'b11;
    run_to(28, "bounce_hi", 2'b01, 1'b1);
    sw_if.rawsw = 2'b01;
    run_to(32, "bounce_lo", 2'b01, 1'b1);
    // Counter must restart from 0: strobes 36,40,44 needed.
    sw_if.rawsw = 2'b11;
    run_to(40, "requal_2nd", 2'b01, 1'b1);
    run_to(43, "requal_pre", 2'b01, 1'b0);
    run_to(44, "requal_set", 2'b11, 1'b1);

    // Falling edge on bit1 only: strobes 48,52,56.
    sw_if.rawsw = 2'b01;
    run_to(52, "fall1_2nd", 2'b11, 1'b1);
    run_to(55, "fall1_pre", 2'b11, 1'b0);
    run_to(56, "fall1_set", 2'b01, 1'b1);

    // Both bits high through reset release: full qualification, same strobe.
    sw_if.rawsw = 2'b11;
    pulse_reset("rst_async_clear");
    run_to(3, "rel_no_strobe", 2'b00, 1'b0);
    run_to(4, "rel_first_strobe", 2'b00, 1'b1);
    run_to(8, "both_2nd", 2'b00, 1'b1);
    run_to(11, "both_pre", 2'b00, 1'b0);
    run_to(12, "both_set", 2'b11, 1'b1);

    // Reset after two qualifying strobes discards the partial count.
    pulse_reset("rst_clear_11");
    run_to(8, "partial_2", 2'b00, 1'b1);
    step();
    pulse_reset("rst_mid_qual");
    run_to(4, "after_rst_s1", 2'b00, 1'b1);
    run_to(8, "after_rst_s2", 2'b00, 1'b1);
    run_to(11, "after_rst_pre", 2'b00, 1'b0);
    run_to(12, "after_rst_set", 2'b11, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
